// File: rtl/gs232c_age_issue_q_if.sv
// Handshake bundle for the age-ordered issue queue: enqueue port,
// wakeup broadcast, issue port and occupancy.
interface gs232c_age_issue_q_if #(
  parameter int DW = 32,
  parameter int TW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_rdy;
  logic [TW-1:0] in_tag;
  logic          wake_valid;
  logic [TW-1:0] wake_tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    out_idx;
  logic [3:0]    occ;

  modport master (
    output in_valid, in_data, in_rdy, in_tag, wake_valid, wake_tag, out_ready,
    input  in_ready, out_valid, out_data, out_idx, occ
  );

  modport slave (
    input  in_valid, in_data, in_rdy, in_tag, wake_valid, wake_tag, out_ready,
    output in_ready, out_valid, out_data, out_idx, occ
  );
endinterface

// File: rtl/gs232c_age_issue_q.sv
// 8-entry age-ordered issue queue. Entries are allocated in order at the
// tail, wait for a tag wakeup, and issue oldest-ready-first out of order.
// Head only advances past issued holes, so occupancy is the head..tail span.
module gs232c_age_issue_q #(
  parameter int DW = 32,
  parameter int TW = 4
) (
  input logic                 clk,
  input logic                 resetn,
  gs232c_age_issue_q_if.slave q
);
  localparam int N = 8;

  logic [N-1:0]  valid, rdy;
  logic [N-1:0]  valid_nxt, rdy_nxt;
  logic [TW-1:0] tag_mem  [N];
  logic [DW-1:0] data_mem [N];
  logic [3:0]    head, tail;
  logic [3:0]    head_nxt, tail_nxt, span_nxt;
  logic [3:0]    occ;
  logic          in_ready;
  logic          enq, iss;
  logic          sel_found;
  logic [2:0]    sel_idx;

  // Span between wrap-extended pointers; holes count toward fullness.
  assign occ      = tail - head;
  assign in_ready = (occ != 4'd8);
  assign enq      = q.in_valid && in_ready;
  assign iss      = sel_found && q.out_ready;

  // Oldest-ready select: scan from head slot upward, wrapping at 8.
  always_comb begin
    logic [2:0] idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = head[2:0] + 3'(k);
      if (!sel_found && valid[idx] && rdy[idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx;
      end
    end
  end

  // Next valid/ready bits: wakeup, then issue clear, then enqueue write.
  // Issue and enqueue never collide because the tail slot is always invalid.
  always_comb begin
    valid_nxt = valid;
    rdy_nxt   = rdy;
    for (int i = 0; i < N; i++) begin
      if (q.wake_valid && valid[i] && !rdy[i] && (tag_mem[i] == q.wake_tag))
        rdy_nxt[i] = 1'b1;
    end
    if (iss) begin
      valid_nxt[sel_idx] = 1'b0;
      rdy_nxt[sel_idx]   = 1'b0;
    end
    if (enq) begin
      valid_nxt[tail[2:0]] = 1'b1;
      rdy_nxt[tail[2:0]]   = q.in_rdy || (q.wake_valid && (q.wake_tag == q.in_tag));
    end
  end

  // Next head: oldest slot still valid after this cycle, else collapse onto tail.
  always_comb begin
    logic [3:0] pos;
    logic       hfound;
    tail_nxt = tail + (enq ? 4'd1 : 4'd0);
    span_nxt = tail_nxt - head;
    head_nxt = tail_nxt;
    hfound   = 1'b0;
    pos      = '0;
    for (int k = 0; k < N; k++) begin
      pos = head + 4'(k);
      if (!hfound && (4'(k) < span_nxt) && valid_nxt[pos[2:0]]) begin
        hfound   = 1'b1;
        head_nxt = pos;
      end
    end
  end

  // Control state: asynchronously cleared, so reset discards every entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid <= '0;
      rdy   <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      valid <= valid_nxt;
      rdy   <= rdy_nxt;
      head  <= head_nxt;
      tail  <= tail_nxt;
    end
  end

  // Payload and tag storage: written on enqueue only, never reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      data_mem[tail[2:0]] <= q.in_data;
      tag_mem[tail[2:0]]  <= q.in_tag;
    end
  end

  // Issue port outputs are forced to zero when nothing is selectable.
  always_comb begin
    q.in_ready  = in_ready;
    q.occ       = occ;
    q.out_valid = sel_found;
    q.out_idx   = sel_found ? sel_idx : 3'd0;
    q.out_data  = sel_found ? data_mem[sel_idx] : '0;
  end
endmodule

// File: tb/tb_gs232c_age_issue_q.sv
// Directed bench for gs232c_age_issue_q: in-order issue, out-of-order
// wakeup, full queue with holes, same-cycle wake at enqueue, pointer wrap,
// and asynchronous reset mid-operation.
module tb_gs232c_age_issue_q;
  logic clk;
  logic resetn;
  int   total;
  int   bad;

  gs232c_age_issue_q_if #(.DW(32), .TW(4)) bus ();

  gs232c_age_issue_q #(.DW(32), .TW(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .q      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", t, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_rdy     = 1'b0;
    bus.in_tag     = '0;
    bus.wake_valid = 1'b0;
    bus.wake_tag   = '0;
    bus.out_ready  = 1'b0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
  endtask

  task automatic enq(input logic [31:0] d, input logic r, input logic [3:0] t);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_rdy   = r;
    bus.in_tag   = t;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // Reset state
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_idx", 32'(bus.out_idx), 32'd0);
    chk("rst_occ", 32'(bus.occ), 32'd0);

    // In-order issue of three ready entries
    enq(32'hA0A0_0001, 1'b1, 4'd0);
    chk("s1_first_sel_idx", 32'(bus.out_idx), 32'd0);
    chk("s1_first_sel_data", bus.out_data, 32'hA0A0_0001);
    enq(32'hB0B0_0002, 1'b1, 4'd0);
    enq(32'hC0C0_0003, 1'b1, 4'd0);
    chk("s1_occ3", 32'(bus.occ), 32'd3);
    bus.out_ready = 1'b1;
    chk("s1_issueA_idx", 32'(bus.out_idx), 32'd0);
    chk("s1_issueA_data", bus.out_data, 32'hA0A0_0001);
    tick();
    chk("s1_occ2", 32'(bus.occ), 32'd2);
    chk("s1_issueB_idx", 32'(bus.out_idx), 32'd1);
    chk("s1_issueB_data", bus.out_data, 32'hB0B0_0002);
    tick();
    chk("s1_occ1", 32'(bus.occ), 32'd1);
    chk("s1_issueC_idx", 32'(bus.out_idx), 32'd2);
    chk("s1_issueC_data", bus.out_data, 32'hC0C0_0003);
    tick();
    chk("s1_occ0", 32'(bus.occ), 32'd0);
    chk("s1_empty", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    enq(32'h0000_0D0D, 1'b1, 4'd0);
    chk("s1_head3_idx", 32'(bus.out_idx), 32'd3);

    // Younger ready entry bypasses a waiting older one
    pulse_reset();
    enq(32'hAAAA_0005, 1'b0, 4'd5);
    enq(32'hBBBB_0006, 1'b1, 4'd0);
    chk("s2_B_idx", 32'(bus.out_idx), 32'd1);
    chk("s2_B_data", bus.out_data, 32'hBBBB_0006);
    chk("s2_occ2", 32'(bus.occ), 32'd2);
    bus.out_ready = 1'b1;
    tick();
    chk("s2_occ_hole", 32'(bus.occ), 32'd2);
    chk("s2_none_ready", 32'(bus.out_valid), 32'd0);
    bus.wake_valid = 1'b1;
    bus.wake_tag   = 4'd5;
    tick();
    bus.wake_valid = 1'b0;
    chk("s2_A_valid", 32'(bus.out_valid), 32'd1);
    chk("s2_A_idx", 32'(bus.out_idx), 32'd0);
    chk("s2_A_data", bus.out_data, 32'hAAAA_0005);
    tick();
    chk("s2_occ0", 32'(bus.occ), 32'd0);
    chk("s2_empty", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    enq(32'h0000_2222, 1'b1, 4'd0);
    chk("s2_head2_idx", 32'(bus.out_idx), 32'd2);

    // Full queue: issuing a hole does not free space until head moves
    pulse_reset();
    for (int i = 0; i < 8; i++) enq(32'h100 + 32'(i), 1'b0, 4'(i));
    chk("s3_full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("s3_full_occ", 32'(bus.occ), 32'd8);
    chk("s3_full_none_ready", 32'(bus.out_valid), 32'd0);
    bus.in_valid   = 1'b1;
    bus.in_rdy     = 1'b1;
    bus.in_data    = 32'hDEAD_BEEF;
    bus.out_ready  = 1'b1;
    bus.wake_valid = 1'b1;
    bus.wake_tag   = 4'd7;
    tick();
    bus.in_valid   = 1'b0;
    bus.wake_valid = 1'b0;
    chk("s3_e7_idx", 32'(bus.out_idx), 32'd7);
    chk("s3_e7_data", bus.out_data, 32'h107);
    tick();
    chk("s3_after7_occ", 32'(bus.occ), 32'd8);
    chk("s3_after7_in_ready", 32'(bus.in_ready), 32'd0);
    chk("s3_after7_empty", 32'(bus.out_valid), 32'd0);
    bus.wake_valid = 1'b1;
    bus.wake_tag   = 4'd0;
    tick();
    bus.wake_valid = 1'b0;
    chk("s3_e0_idx", 32'(bus.out_idx), 32'd0);
    chk("s3_e0_data", bus.out_data, 32'h100);
    tick();
    chk("s3_after0_occ", 32'(bus.occ), 32'd7);
    chk("s3_after0_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
    bus.wake_valid = 1'b1;
    bus.wake_tag   = 4'd12;
    tick();
    bus.wake_valid = 1'b0;
    chk("s3_nomatch_wake", 32'(bus.out_valid), 32'd0);

    // Wakeup in the same cycle as enqueue of the awaited tag
    pulse_reset();
    bus.wake_valid = 1'b1;
    bus.wake_tag   = 4'd3;
    enq(32'h3333_3333, 1'b0, 4'd3);
    bus.wake_valid = 1'b0;
    chk("s4_sel_valid", 32'(bus.out_valid), 32'd1);
    chk("s4_sel_idx", 32'(bus.out_idx), 32'd0);
    chk("s4_sel_data", bus.out_data, 32'h3333_3333);
    bus.out_ready = 1'b1;
    tick();
    chk("s4_empty", 32'(bus.out_valid), 32'd0);
    chk("s4_occ0", 32'(bus.occ), 32'd0);
    bus.out_ready = 1'b0;

    // Pointer wrap: move head/tail to 6, then four ready entries
    pulse_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_rdy    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_data = 32'h50 + 32'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    chk("s5_pre_occ0", 32'(bus.occ), 32'd0);
    chk("s5_pre_empty", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) enq(32'h600 + 32'(i), 1'b1, 4'd0);
    chk("s5_occ4", 32'(bus.occ), 32'd4);
    bus.out_ready = 1'b1;
    chk("s5_idx6", 32'(bus.out_idx), 32'd6);
    chk("s5_data6", bus.out_data, 32'h600);
    tick();
    chk("s5_idx7", 32'(bus.out_idx), 32'd7);
    chk("s5_data7", bus.out_data, 32'h601);
    tick();
    chk("s5_idx0", 32'(bus.out_idx), 32'd0);
    chk("s5_data0", bus.out_data, 32'h602);
    tick();
    chk("s5_idx1", 32'(bus.out_idx), 32'd1);
    chk("s5_data1", bus.out_data, 32'h603);
    tick();
    chk("s5_post_occ0", 32'(bus.occ), 32'd0);
    chk("s5_post_empty", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // Asynchronous reset between clock edges with five entries queued
    pulse_reset();
    for (int i = 0; i < 5; i++) enq(32'h700 + 32'(i), 1'b1, 4'd0);
    chk("s6_occ5", 32'(bus.occ), 32'd5);
    resetn = 1'b0;
    #1;
    chk("s6_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("s6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("s6_rst_out_data", bus.out_data, 32'd0);
    chk("s6_rst_out_idx", 32'(bus.out_idx), 32'd0);
    chk("s6_rst_occ", 32'(bus.occ), 32'd0);
    resetn = 1'b1;
    enq(32'h0000_7777, 1'b1, 4'd0);
    chk("s6_post_idx", 32'(bus.out_idx), 32'd0);
    chk("s6_post_data", bus.out_data, 32'h0000_7777);
    chk("s6_post_occ1", 32'(bus.occ), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gs232c_age_issue_q.md
GS232C_AGE_ISSUE_Q -- requirements
Module: gs232c_age_issue_q

Interface
REQ-001 Parameter DW, default 32: payload width per entry.
REQ-002 Parameter TW, default 4: wakeup tag width.
REQ-003 Entry count SHALL be fixed at 8, with 3-bit index and 4-bit wrap-extended head/tail pointers.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  enqueue request.
REQ-007 in_ready  output  1  queue can accept an entry.
REQ-008 in_data  input  DW  payload.
REQ-009 in_rdy  input  1  entry is ready at enqueue.
REQ-010 in_tag  input  TW  tag awaited when in_rdy=0.
REQ-011 wake_valid  input  1  wakeup broadcast.
REQ-012 wake_tag  input  TW  broadcast tag.
REQ-013 out_valid  output  1  at least one valid, ready entry exists.
REQ-014 out_ready  input  1  consumer accepts the selected entry.
REQ-015 out_data  output  DW  payload of the selected entry.
REQ-016 out_idx  output  3  index of the selected entry.
REQ-017 occ  output  4  span tail-head, range 0..8.

Function
REQ-018 Per entry state SHALL be: valid, rdy, tag, data.
REQ-019 Enqueue SHALL occur on in_valid&&in_ready.
- Write to entry tail[2:0] with valid=1.
- Set rdy=in_rdy OR (wake_valid && wake_tag==in_tag).
- Increment tail by 1 modulo 16.
REQ-020 in_ready SHALL be (occ!=8), computed from registered state only; a same-cycle issue does not free space.
REQ-021 Wakeup SHALL set rdy on every valid entry with rdy=0 and tag==wake_tag, effective in the next cycle.
REQ-022 Selection SHALL pick the first entry with valid&&rdy, scanning from head[2:0] upward with wrap at 8, i.e. the oldest ready entry.
- Selection is combinational from registered state.
- out_valid, out_data and out_idx reflect the selection in the same cycle.
REQ-023 When out_valid=0, out_data SHALL be 0 and out_idx SHALL be 0.
REQ-024 Issue SHALL occur on out_valid&&out_ready and clear valid of entry out_idx at the clock edge; entries issue out of order and leave holes.
REQ-025 Next head SHALL be the wrap-extended position of the oldest entry still valid after this cycle's issue, scanning from head toward tail.
- If no such entry exists, next head SHALL equal next tail.
- This computation includes an entry enqueued in the same cycle.
REQ-026 occ SHALL be tail-head modulo 16; it counts holes between head and tail, so in_ready follows span, not live-entry count.
REQ-027 An enqueued entry SHALL first be selectable in the cycle after enqueue; issue-to-empty latency is 0 cycles from selection.
REQ-028 Simultaneous enqueue, wakeup and issue in one cycle SHALL all take effect, with no priority conflict.
- Issue clears only out_idx.
- Enqueue writes only old tail, which is invalid by construction.
REQ-029 Wakeup of a tag matched by no entry SHALL have no effect; a wakeup to an already-ready entry SHALL have no effect.
REQ-030 Payload and tag of invalid entries SHALL be don't-care; valid and rdy are the only architecturally visible bits.

Reset
REQ-031 Assertion of resetn=0 SHALL asynchronously clear all valid and rdy bits and set head=tail=0.
- Resulting outputs: in_ready=1, out_valid=0, out_data=0, out_idx=0, occ=0.
REQ-032 Reset mid-operation SHALL discard all entries, with no partial issue or enqueue at the reset edge.
REQ-033 Data and tag storage SHALL need no reset.

Verification
REQ-034 Enqueue A(rdy=1), B(rdy=1), C(rdy=1) with out_ready=0, then hold out_ready=1 -> issue order A,B,C at idx 0,1,2; occ goes 3,2,1,0; head ends at 3.
REQ-035 Enqueue A(rdy=0,tag=5), B(rdy=1) -> B issues first at idx 1.
- occ stays 2 because A is still valid at head.
- wake_tag=5 one cycle later -> A issues the following cycle; head=tail=2.
REQ-036 Fill 8 entries, all rdy=0 -> in_ready=0, occ=8.
- Wake entry 7 and issue it -> occ stays 8, in_ready stays 0.
- Wake entry 0 and issue it -> head advances to 1, occ=7, in_ready=1.
REQ-037 Enqueue with in_tag=3, in_rdy=0 in the same cycle as wake_valid=1, wake_tag=3 -> entry is ready and issues the next cycle.
REQ-038 Drive head and tail to 6, enqueue 4 ready entries -> idx 6,7,0,1 are selected in that order across the wrap; occ=4 before issue.
REQ-039 With 5 entries valid, pulse resetn=0 between clock edges -> outputs go to reset values immediately.
- After release, the next enqueue lands at idx 0.
